// File: rtl/cpu_pkg.sv
// Shared core types: tag owner, arbiter FSM states,
// in-flight read tag bundle and memory latency limits.
package cpu_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   drop;
  } tag_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Read-tag shift register matching memory latency.
// Flush marks in-flight fetch tags so they never respond.
module mem_arb_tag_pipe
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_valid,
  input  owner_e push_owner,
  input  logic   flush,
  output tag_t   exit_tag,
  output logic   any_valid
);

  tag_t [MEM_LAT-1:0] stage_q;
  tag_t [MEM_LAT-1:0] next_q;

  // new tag enters clean; older fetch tags pick up drop
  always_comb begin
    next_q    = '0;
    next_q[0] = '{valid: push_valid,
                  owner: push_owner,
                  drop:  1'b0};
    for (int i = 1; i < MEM_LAT; i++) begin
      next_q[i] = stage_q[i-1];
      if (flush && stage_q[i-1].owner == OWN_IF)
        next_q[i].drop = 1'b1;
    end
  end

  // advance the pipe; reset discards every pending tag
  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= next_q;
  end

  // any tag still awaiting its response
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < MEM_LAT; i++)
      any_valid = any_valid | stage_q[i].valid;
  end

  assign exit_tag = stage_q[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// IF / MEM port arbiter for one shared memory.
// ARB_PERF_EN adds conflict and starvation counters.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              if_flush,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              halt_req,
  output logic              halted
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_starve
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  if (!mem_lat_ok(MEM_LAT)) begin : g_lat_chk
    $error("MEM_LAT outside 1..4");
  end

  arb_state_e    state_q;
  arb_state_e    state_d;
  logic [SW-1:0] starve_q;
  logic          force_if;
  logic          any_valid;
  logic          rd_push;
  owner_e        push_owner;
  tag_t          exit_tag;

  assign force_if = (starve_q == SMAX);

  // data has priority unless fetch has starved long enough
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst && state_q == RUN) begin
      priority case (1'b1)
        (dm_req && !(if_req && force_if)): dm_gnt = 1'b1;
        if_req:                            if_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_en    = if_gnt | dm_gnt;
  assign mem_we    = dm_gnt & dm_we;
  assign mem_addr  = dm_gnt ? dm_addr : if_addr;
  assign mem_wdata = dm_wdata;

  assign rd_push    = mem_en & ~mem_we;
  assign push_owner = dm_gnt ? OWN_DM : OWN_IF;

  // count consecutive denied fetch cycles
  always_ff @(posedge clk) begin
    if (rst || !if_req || if_gnt)
      starve_q <= '0;
    else if (!force_if)
      starve_q <= starve_q + SW'(1);
  end

  mem_arb_tag_pipe #(
    .MEM_LAT    (MEM_LAT)
  ) u_tags (
    .clk        (clk),
    .rst        (rst),
    .push_valid (rd_push),
    .push_owner (push_owner),
    .flush      (if_flush),
    .exit_tag   (exit_tag),
    .any_valid  (any_valid)
  );

  assign if_rvalid = exit_tag.valid
                   & (exit_tag.owner == OWN_IF)
                   & ~exit_tag.drop
                   & ~if_flush;
  assign dm_rvalid = exit_tag.valid
                   & (exit_tag.owner == OWN_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // run, then drain pending reads, then park in halt
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt_req)   state_d = DRAIN;
      DRAIN:   if (!any_valid) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  assign halted = (state_q == HALT);

`ifdef ARB_PERF_EN
  // wrapping event counters, frozen once halted
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict <= '0;
      perf_starve   <= '0;
    end else if (state_q != HALT) begin
      if (if_req && dm_req)
        perf_conflict <= perf_conflict + 32'd1;
      if (if_gnt && dm_req)
        perf_starve <= perf_starve + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a
// latency-3 memory model behind the shared port.
module tb_mem_port_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid, if_flush;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          halt_req, halted;
`ifdef ARB_PERF_EN
  logic [31:0]   perf_conflict, perf_starve;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_flush(if_flush),
    .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .halt_req(halt_req), .halted(halted)
`ifdef ARB_PERF_EN
    ,
    .perf_conflict(perf_conflict),
    .perf_starve(perf_starve)
`endif
  );

  function automatic logic [DW-1:0] init_val(
    input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // external memory: write-through, LAT-cycle read
  logic [DW-1:0] ram [1024];
  bit            ram_wr [1024];
  logic [DW-1:0] rd_pipe [LAT];
  int            cyc = 0;

  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    if (mem_en && !mem_we)
      rd_pipe[0] <= ram_wr[mem_addr] ? ram[mem_addr]
                                     : init_val(mem_addr);
    else
      rd_pipe[0] <= 32'h0BAD_0BAD;
    for (int i = 1; i < LAT; i++)
      rd_pipe[i] <= rd_pipe[i-1];
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          if_q[$];
  exp_t          dm_q[$];
  logic [DW-1:0] ref_mem [1024];
  bit            ref_wr [1024];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  function automatic logic [DW-1:0] ref_rd(
    input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  // scoreboard: retire due responses, push new grants
  task automatic sb_cycle();
    logic ev;
    exp_t e;
    if (rst) begin
      if_q.delete();
      dm_q.delete();
      total_cnt++;
      if ({if_gnt, dm_gnt, mem_en} !== 3'b000)
        $display("FAIL rst_gate cyc=%0d got %b want 000",
                 cyc, {if_gnt, dm_gnt, mem_en});
      else pass_cnt++;
      return;
    end
    if (if_flush) if_q.delete();
    ev = (if_q.size() > 0) && (if_q[0].due == cyc);
    total_cnt++;
    if (if_rvalid !== ev ||
        (ev && if_rdata !== if_q[0].data))
      $display("FAIL if_resp cyc=%0d got v=%b d=%h want v=%b d=%h",
               cyc, if_rvalid, if_rdata, ev,
               ev ? if_q[0].data : '0);
    else pass_cnt++;
    if (ev) void'(if_q.pop_front());
    ev = (dm_q.size() > 0) && (dm_q[0].due == cyc);
    total_cnt++;
    if (dm_rvalid !== ev ||
        (ev && dm_rdata !== dm_q[0].data))
      $display("FAIL dm_resp cyc=%0d got v=%b d=%h want v=%b d=%h",
               cyc, dm_rvalid, dm_rdata, ev,
               ev ? dm_q[0].data : '0);
    else pass_cnt++;
    if (ev) void'(dm_q.pop_front());
    if (if_gnt) begin
      e.data = ref_rd(if_addr);
      e.due  = cyc + LAT;
      if_q.push_back(e);
    end
    if (dm_gnt) begin
      if (dm_we) begin
        ref_mem[dm_addr] = dm_wdata;
        ref_wr[dm_addr]  = 1'b1;
      end else begin
        e.data = ref_rd(dm_addr);
        e.due  = cyc + LAT;
        dm_q.push_back(e);
      end
    end
  endtask

  task automatic drive_step();
    @(posedge clk);
    #1;
    if_req   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    if_flush = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    sb_cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive_step();
      sample();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    drive_step();
    rst = 1'b0;
    sample();
    total_cnt++;
    if (if_rvalid !== 1'b0)
      $display("FAIL reset_if_rvalid got %b want 0", if_rvalid);
    else pass_cnt++;
    total_cnt++;
    if (dm_rvalid !== 1'b0)
      $display("FAIL reset_dm_rvalid got %b want 0", dm_rvalid);
    else pass_cnt++;
    total_cnt++;
    if (halted !== 1'b0)
      $display("FAIL reset_halted got %b want 0", halted);
    else pass_cnt++;
  endtask

  task automatic test_fetch();
    for (int k = 0; k < 3; k++) begin
      drive_step();
      if_req  = 1'b1;
      if_addr = AW'(k);
      sample();
      total_cnt++;
      if (if_gnt !== 1'b1 || dm_gnt !== 1'b0)
        $display("FAIL fetch_gnt k=%0d got %b%b want 10",
                 k, if_gnt, dm_gnt);
      else pass_cnt++;
    end
    idle(LAT + 1);
  endtask

  task automatic test_conflict();
    logic wi;
    for (int k = 0; k < 6; k++) begin
      drive_step();
      if_req  = 1'b1;
      if_addr = 10'd50;
      dm_req  = 1'b1;
      dm_addr = 10'd100;
      sample();
      wi = (k == 4);
      total_cnt++;
      if (if_gnt !== wi || dm_gnt !== !wi)
        $display("FAIL conflict_gnt k=%0d got %b%b want %b%b",
                 k, if_gnt, dm_gnt, wi, !wi);
      else pass_cnt++;
    end
    idle(LAT + 1);
`ifdef ARB_PERF_EN
    total_cnt++;
    if (perf_conflict !== 32'd6 || perf_starve !== 32'd1)
      $display("FAIL perf got %0d/%0d want 6/1",
               perf_conflict, perf_starve);
    else pass_cnt++;
`endif
  endtask

  task automatic test_store();
    drive_step();
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 10'd5;
    dm_wdata = 32'hDEADBEEF;
    sample();
    total_cnt++;
    if (!(dm_gnt === 1'b1 && mem_en === 1'b1 &&
          mem_we === 1'b1 && mem_addr === 10'd5 &&
          mem_wdata === 32'hDEADBEEF))
      $display("FAIL store_strobe got g=%b en=%b we=%b a=%0d d=%h want 1 1 1 5 deadbeef",
               dm_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    drive_step();
    sample();
    total_cnt++;
    if (mem_we !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL store_once got en=%b we=%b want 0 0",
               mem_en, mem_we);
    else pass_cnt++;
    drive_step();
    dm_req  = 1'b1;
    dm_addr = 10'd5;
    sample();
    idle(LAT - 1);
    drive_step();
    sample();
    total_cnt++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hDEADBEEF)
      $display("FAIL store_readback got v=%b d=%h want 1 deadbeef",
               dm_rvalid, dm_rdata);
    else pass_cnt++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      drive_step();
      if_req  = 1'b1;
      if_addr = AW'(60 + k);
      dm_req  = k[0];
      dm_addr = AW'(200 + k);
      sample();
      total_cnt++;
      if (mem_en !== 1'b1)
        $display("FAIL b2b_en k=%0d got %b want 1", k, mem_en);
      else pass_cnt++;
    end
    idle(LAT + 1);
  endtask

  task automatic test_flush();
    int            n_rv;
    logic [DW-1:0] d_rv;
    for (int k = 0; k < 3; k++) begin
      drive_step();
      if_req  = 1'b1;
      if_addr = AW'(10 + k);
      sample();
    end
    drive_step();
    if_req   = 1'b1;
    if_addr  = 10'd40;
    if_flush = 1'b1;
    sample();
    total_cnt++;
    if (if_gnt !== 1'b1 || if_rvalid !== 1'b0)
      $display("FAIL flush_cycle got g=%b v=%b want 1 0",
               if_gnt, if_rvalid);
    else pass_cnt++;
    n_rv = 0;
    d_rv = '0;
    repeat (LAT + 1) begin
      drive_step();
      sample();
      if (if_rvalid === 1'b1) begin
        n_rv++;
        d_rv = if_rdata;
      end
    end
    total_cnt++;
    if (n_rv != 1 || d_rv !== 32'hC0DE_0028)
      $display("FAIL flush_only40 got n=%0d d=%h want 1 c0de0028",
               n_rv, d_rv);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid_read();
    drive_step();
    dm_req  = 1'b1;
    dm_addr = 10'd300;
    sample();
    drive_step();
    rst     = 1'b1;
    if_req  = 1'b1;
    dm_req  = 1'b1;
    sample();
    drive_step();
    rst = 1'b0;
    sample();
    total_cnt++;
    if ({if_rvalid, dm_rvalid, halted} !== 3'b000)
      $display("FAIL rst_mid_state got %b want 000",
               {if_rvalid, dm_rvalid, halted});
    else pass_cnt++;
    idle(LAT + 1);
  endtask

  task automatic test_halt_drain();
    logic hexp;
    drive_step();
    if_req  = 1'b1;
    if_addr = 10'd7;
    sample();
    drive_step();
    dm_req  = 1'b1;
    dm_addr = 10'd8;
    sample();
    drive_step();
    halt_req = 1'b1;
    sample();
    total_cnt++;
    if (halted !== 1'b0)
      $display("FAIL halt_early got %b want 0", halted);
    else pass_cnt++;
    for (int j = 3; j < 8; j++) begin
      drive_step();
      if_req  = 1'b1;
      if_addr = 10'd9;
      dm_req  = 1'b1;
      dm_addr = 10'd9;
      sample();
      hexp = (j >= 6);
      total_cnt++;
      if (halted !== hexp || if_gnt !== 1'b0 ||
          dm_gnt !== 1'b0)
        $display("FAIL halt_seq j=%0d got h=%b g=%b%b want h=%b g=00",
                 j, halted, if_gnt, dm_gnt, hexp);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst      = 1'b1;
    if_req   = 1'b0;
    if_addr  = '0;
    if_flush = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    halt_req = 1'b0;
    test_reset();
    test_fetch();
    test_conflict();
    test_store();
    test_back_to_back();
    test_flush();
    test_rst_mid_read();
    test_halt_drain();
    total_cnt++;
    if (if_q.size() != 0 || dm_q.size() != 0)
      $display("FAIL pending_resp got %0d/%0d want 0/0",
               if_q.size(), dm_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
